// File: rtl/word_buf_pkg.sv
// Shared types and constants for the pixel word write buffer.
// No logic; constants only.
// Imported by word_fifo and word_write_buffer.
package word_buf_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int ADDR_STEP      = BYTES_PER_WORD;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

endpackage

// File: rtl/word_fifo.sv
// Synchronous FIFO for packed pixel words; head is presented combinationally.
// Latency: a word pushed at an edge is visible on rdata right after that edge.
// Backpressure: push when full and pop when empty are ignored; clear empties the FIFO.
module word_fifo
  import word_buf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = WORD_W
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array: written at the tail on an accepted push, no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok && !clear) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!n_rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/word_write_buffer.sv
// Buffers packed pixel words and writes them to pixel memory with sequential addresses.
// Latency: word captured at edge k raises mem_wr_req after edge k+1; one word per 2 cycles max.
// Backpressure: none upstream; words arriving while the FIFO is full are dropped and flagged.
module word_write_buffer
  import word_buf_pkg::*;
#(
  parameter int                DEPTH       = 4,
  parameter int                ADDR_W      = 18,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                FRAME_WORDS = 19200
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic                word_valid,
  input  logic [WORD_W-1:0]   word_in,
  output logic                mem_wr_req,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [WORD_W-1:0]   mem_wdata,
  input  logic                mem_wr_ack,
  output logic                frame_done,
  output logic                overflow,
  output logic                busy
);

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int WCNT_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   addr_cnt;
  logic [WCNT_W-1:0]   word_cnt;
  logic                last_word;

  logic                fifo_push;
  logic                fifo_pop;
  logic [WORD_W-1:0]   fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic [CNT_W-1:0]    count_nxt;

  // start wins over both a same-cycle word and a same-cycle ack.
  assign fifo_push = word_valid && !fifo_full && !start;
  assign fifo_pop  = (state == REQ) && mem_wr_ack && !start;
  assign last_word = (word_cnt == WCNT_W'(FRAME_WORDS - 1));

  word_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .clear (start),
    .wdata (word_in),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Next state and next occupancy, so busy can be registered alongside state.
  always_comb begin
    state_nxt = state;
    count_nxt = fifo_count;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = REQ;
      REQ:     if (mem_wr_ack)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (fifo_push) count_nxt = count_nxt + 1'b1;
    if (fifo_pop)  count_nxt = count_nxt - 1'b1;
  end

  // Writer FSM, address/word counters, frame and overflow flags.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state      <= IDLE;
      mem_wr_req <= 1'b0;
      mem_addr   <= BASE_ADDR;
      mem_wdata  <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      busy       <= 1'b0;
      addr_cnt   <= BASE_ADDR;
      word_cnt   <= '0;
    end else if (start) begin
      state      <= IDLE;
      mem_wr_req <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      busy       <= 1'b0;
      addr_cnt   <= BASE_ADDR;
      word_cnt   <= '0;
    end else begin
      frame_done <= 1'b0;
      busy       <= (count_nxt != '0) || (state_nxt == REQ);
      state      <= state_nxt;
      if (word_valid && fifo_full) begin
        overflow <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            mem_wr_req <= 1'b1;
            mem_addr   <= addr_cnt;
            mem_wdata  <= fifo_head;
          end
        end
        REQ: begin
          if (mem_wr_ack) begin
            mem_wr_req <= 1'b0;
            if (last_word) begin
              frame_done <= 1'b1;
              addr_cnt   <= BASE_ADDR;
              word_cnt   <= '0;
            end else begin
              addr_cnt   <= addr_cnt + ADDR_W'(ADDR_STEP);
              word_cnt   <= word_cnt + 1'b1;
            end
          end
        end
        default: mem_wr_req <= 1'b0;
      endcase
    end
  end

endmodule

// File: doc/word_write_buffer.md
Name: word_write_buffer

Overview:
- Downstream stage of the 8-to-32 pixel packer in the edge-detection datapath.
- Accepts packed 32-bit pixel words (four 8-bit pixels) as single-cycle valid pulses and buffers them in a small FIFO.
- Drains them to pixel memory through a req/ack write handshake, generating sequential word addresses and flagging end of frame.

Parameters:
- DEPTH, 4, FIFO depth in words; power of 2, ≥2.
- ADDR_W, 18, memory byte-address width.
- BASE_ADDR, 18'h00000, byte address of the first word of a frame.
- FRAME_WORDS, 19200, words per frame (320x240 8-bit pixels / 4).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- n_rst  in  1  synchronous active-low reset, sampled on rising edge of clk.
- start  in  1  one-cycle pulse: begin new frame; clears buffer/counters.
- word_valid  in  1  one-cycle pulse: word_in holds a complete packed word.
- word_in  in  32  packed pixel word; byte 3 is oldest pixel.
- mem_wr_req  out  1  write request; held until acknowledged.
- mem_addr  out  ADDR_W  byte address of the current write.
- mem_wdata  out  32  data of the current write.
- mem_wr_ack  in  1  one-cycle pulse: memory accepted the current write.
- frame_done  out  1  one-cycle pulse after last word of frame acknowledged.
- overflow  out  1  sticky: a word arrived while FIFO full.
- busy  out  1  FIFO non-empty or write outstanding.

Behaviour:
- Reset (n_rst=0 at edge): FIFO empty; state IDLE; mem_wr_req=0, mem_addr=BASE_ADDR, mem_wdata=0, frame_done=0, overflow=0, busy=0; word counter=0.
- All outputs registered.
- Push: word_valid=1 and count<DEPTH → word_in written at the tail that edge. A same-cycle pop does not free space for the push.
- word_valid=1 with count==DEPTH → word dropped, overflow set; it stays set until start or reset.
- Writer FSM, states IDLE and REQ:
  - IDLE: if FIFO non-empty at an edge → REQ; the same edge loads mem_wdata=head, mem_addr=address counter, mem_wr_req=1.
  - REQ: mem_wr_req, mem_addr and mem_wdata are held stable until mem_wr_ack=1.
  - On ack: pop head; address counter += 4; word counter += 1; mem_wr_req=0; → IDLE.
  - At least one low cycle of mem_wr_req separates consecutive writes. Max throughput is one word per 2 cycles.
- mem_wr_ack while in IDLE is ignored.
- Latency: word captured at edge k → mem_wr_req high after edge k+1.
- Frame end: the ack of word FRAME_WORDS-1 (zero-based count) causes:
  - frame_done=1 for exactly the following cycle;
  - address counter wraps to BASE_ADDR;
  - word counter wraps to 0.
  - Buffered words continue into the next frame.
- Address arithmetic is modulo 2^ADDR_W; no other wrap.
- start=1 at an edge:
  - empties the FIFO; clears the address counter to BASE_ADDR, the word counter, overflow and frame_done;
  - forces IDLE with mem_wr_req=0.
  - An outstanding request is abandoned.
  - start takes priority over a same-cycle word_valid (word discarded) and mem_wr_ack (ack ignored).
- busy = (count≠0) or (state==REQ), registered alongside state.
- Reset mid-request: same as start, plus all outputs return to reset values.

Decomposition:
- Package word_buf_pkg holds:
  - state_t enum {IDLE, REQ};
  - localparams WORD_W=32, BYTES_PER_WORD=4, ADDR_STEP=4.
- One sub-module: word_fifo.
  - Synchronous FIFO with parameters DEPTH and width 32.
  - Ports: push, pop, clear, wdata, rdata (head, combinational), full, empty, count.
  - Uses the same synchronous active-low reset.
- The top level holds the FSM, address/word counters and the overflow flag.

Test Plan:
- Reset, single word, FRAME_WORDS=4: word_in=32'h25326485 pulsed → mem_wr_req high after next edge with mem_addr=0x00000, mem_wdata=32'h25326485. Ack after 3 cycles → req low, busy low.
- Burst: DEPTH=4, ack held off; push 5 words 32'h11111111..32'h55555555 on consecutive cycles → words 1–4 buffered, 5th dropped, overflow=1. Then ack every request → addresses 0x0,0x4,0x8,0xC with matching data.
- Frame wrap, FRAME_WORDS=4: write 5 words with immediate acks → frame_done pulses once, one cycle after 4th ack; 5th word written at 0x00000.
- Start mid-request: req outstanding at 0x8, 2 words buffered; pulse start with same-cycle ack → req=0 next cycle, FIFO empty, overflow=0. Next word goes to 0x00000.
- Simultaneous: word_valid at the same edge as the ack of the only buffered word → new word kept, next request at addr+4 after one idle cycle. Spurious ack in IDLE → no change to address or counters.
